// File: rtl/decoder_addr_seq.sv
// Address sequencer driving the 3-to-8 decoder selects {a,b,c} under a valid/ready handshake.
// Optional macro DEC_ADDR_GRAY_EN: present the Gray code of the internal binary counter on {a,b,c}.
module decoder_addr_seq #(
    parameter int         SWEEP_W    = 8,
    parameter logic [2:0] START_ADDR = 3'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               load,
    input  logic [2:0]         load_val,
    input  logic               ready,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               valid,
    output logic               wrap,
    output logic [SWEEP_W-1:0] sweeps
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PP   = 2'b10;
    localparam logic [SWEEP_W-1:0] SWEEP_MAX = {SWEEP_W{1'b1}};

    function automatic logic [2:0] addr_to_out(input logic [2:0] v);
`ifdef DEC_ADDR_GRAY_EN
        addr_to_out = v ^ {1'b0, v[2:1]};
`else
        addr_to_out = v;
`endif
    endfunction

    state_t             state_r, state_nx;
    logic [2:0]         addr_r, addr_nx;
    logic               dir_r, dir_nx;      // 1 = counting down
    logic [2:0]         out_r;
    logic               valid_r;
    logic               wrap_r, wrap_nx;
    logic [SWEEP_W-1:0] sweeps_r, sweeps_nx;
    logic               accept_s;
    logic               advance_s;

    assign {a, b, c} = out_r;
    assign valid     = valid_r;
    assign wrap      = wrap_r;
    assign sweeps    = sweeps_r;

    // Handshake, FSM next state, counter advance and wrap detection
    always_comb begin
        state_nx  = state_r;
        addr_nx   = addr_r;
        dir_nx    = dir_r;
        wrap_nx   = 1'b0;
        accept_s  = valid_r & ready;
        // A beat accepted while draining is consumed without advancing
        advance_s = accept_s && (state_r == RUN);

        case (state_r)
            IDLE: begin
                if (en) state_nx = RUN;
                else    state_nx = IDLE;
            end
            RUN: begin
                if (!en) state_nx = accept_s ? IDLE : DRAIN;
                else     state_nx = RUN;
            end
            DRAIN: begin
                if (accept_s) state_nx = IDLE;
                else if (en)  state_nx = RUN;
                else          state_nx = DRAIN;
            end
            default: state_nx = IDLE;
        endcase

        if (load) begin
            addr_nx = load_val;
            dir_nx  = 1'b0;
        end else if (advance_s) begin
            case (mode)
                MODE_UP: begin
                    addr_nx = addr_r + 3'd1;
                    dir_nx  = 1'b0;
                    wrap_nx = (addr_r == 3'd7);
                end
                MODE_DOWN: begin
                    addr_nx = addr_r - 3'd1;
                    dir_nx  = 1'b1;
                    wrap_nx = (addr_r == 3'd0);
                end
                MODE_PP: begin
                    // Endpoints force the direction so each is emitted exactly once
                    if (addr_r == 3'd7) begin
                        addr_nx = 3'd6;
                        dir_nx  = 1'b1;
                        wrap_nx = 1'b1;
                    end else if (addr_r == 3'd0) begin
                        addr_nx = 3'd1;
                        dir_nx  = 1'b0;
                        wrap_nx = 1'b1;
                    end else if (dir_r) begin
                        addr_nx = addr_r - 3'd1;
                    end else begin
                        addr_nx = addr_r + 3'd1;
                    end
                end
                default: begin
                    addr_nx = addr_r;
                end
            endcase
        end else begin
            addr_nx = addr_r;
        end

        if (wrap_nx && (sweeps_r != SWEEP_MAX)) sweeps_nx = sweeps_r + SWEEP_W'(1);
        else                                    sweeps_nx = sweeps_r;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            addr_r   <= START_ADDR;
            dir_r    <= 1'b0;
            out_r    <= addr_to_out(START_ADDR);
            valid_r  <= 1'b0;
            wrap_r   <= 1'b0;
            sweeps_r <= '0;
        end else begin
            state_r  <= state_nx;
            addr_r   <= addr_nx;
            dir_r    <= dir_nx;
            out_r    <= addr_to_out(addr_nx);
            valid_r  <= (state_nx != IDLE);
            wrap_r   <= wrap_nx;
            sweeps_r <= sweeps_nx;
        end
    end

endmodule
